// File: rtl/poly_operand_feeder.sv
// -----------------------------------------------------------------------------
// poly_operand_feeder
//
// Streams operand A and operand B words from the shared polynomial RAM into the
// butterfly array for the two-operand modes: pointwise multiply (MULT) and
// coefficient add/sub (ADDSUB). One word is issued every P cycles (P = 4 for
// MULT, P = 2 for ADDSUB). For word k, starting at cycle s_k = 1 + k*P, where
// cycle 0 is the cycle right after the edge that accepted start:
//   s_k     : read A_k
//   s_k + 1 : read B_k, bf_pre_load (A_k on bf_in_data)
//   s_k + 2 : bf_load (B_k on bf_in_data); MULT: zeta read for P cycles
//   s_k + 3 .. s_k + 2 + P : processing window, bf_stage sequenced per cycle
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   start, op, sub    : run request; op 1 = MULT, 0 = ADDSUB; sub = subtract
//   busy, done        : run in progress / one-cycle completion pulse
//   mem_en, mem_addr  : polynomial RAM read port, addr = {B select, word}
//   mem_rdata         : RAM data, 1-cycle latency, holds when not enabled
//   zeta_en/addr/rdata: zeta ROM read port, same latency rules
//   bf_mode, bf_stage, bf_type, bf_pre_load, bf_load : butterfly control
//   bf_in_data        : mem_rdata pass-through
//   bf_in_coef        : zeta_rdata in MULT, zero otherwise
//
// Handshake: start is a single-cycle request with no ready; it is accepted on a
// rising edge only while the block is idle (busy = 0 and done = 0, and not in
// the cycle just before the first issue cycle) and is silently dropped at any
// other time.
// -----------------------------------------------------------------------------
module poly_operand_feeder #(
  parameter int WORDS = 32,
  parameter int AW    = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op,
  input  logic            sub,
  output logic            busy,
  output logic            done,
  output logic            mem_en,
  output logic [AW:0]     mem_addr,
  input  logic [95:0]     mem_rdata,
  output logic            zeta_en,
  output logic [AW-1:0]   zeta_addr,
  input  logic [23:0]     zeta_rdata,
  output logic [1:0]      bf_mode,
  output logic [2:0]      bf_stage,
  output logic            bf_type,
  output logic            bf_pre_load,
  output logic            bf_load,
  output logic [95:0]     bf_in_data,
  output logic [23:0]     bf_in_coef
);

  // Cycle counter width: must hold WORDS*4 + 4.
  localparam int CW = AW + 4;

  localparam logic [1:0] MODE_MULT   = 2'd2;
  localparam logic [1:0] MODE_ADDSUB = 2'd3;

  // Last busy cycle number for each mode: s_{WORDS-1} + 2 + P = WORDS*P + 3.
  localparam logic [CW-1:0] LAST_MULT   = CW'(WORDS * 4 + 3);
  localparam logic [CW-1:0] LAST_ADDSUB = CW'(WORDS * 2 + 3);
  localparam logic [CW-1:0] WORDS_C     = CW'(WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cyc_q, cyc_d;        // number of the cycle currently shown
  logic            op_q, op_d;
  logic [1:0]      bf_mode_q, bf_mode_d;
  logic            bf_type_q, bf_type_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            mem_en_q, mem_en_d;
  logic [AW:0]     mem_addr_q, mem_addr_d;
  logic            zeta_en_q, zeta_en_d;
  logic [AW-1:0]   zeta_addr_q, zeta_addr_d;
  logic [2:0]      bf_stage_q, bf_stage_d;
  logic            bf_pre_load_q, bf_pre_load_d;
  logic            bf_load_q, bf_load_d;

  // Next-cycle decode. nxt is the number of the cycle whose outputs are being
  // computed; each event is found by offsetting nxt and splitting the result
  // into a word index (divide by P) and a phase (mod P).
  logic [CW-1:0]   nxt;
  logic [CW-1:0]   last_busy;
  logic [1:0]      shamt;
  logic [1:0]      pmask;
  logic [CW-1:0]   m1, m3, m4;
  logic [CW-1:0]   k1, k3, k4;
  logic [1:0]      ph1, ph3, ph4;

  always_comb begin
    nxt       = cyc_q + CW'(1);
    last_busy = op_q ? LAST_MULT : LAST_ADDSUB;
    shamt     = op_q ? 2'd2 : 2'd1;
    pmask     = op_q ? 2'b11 : 2'b01;

    // Offset 1: operand reads (phase 0 = A, phase 1 = B + pre-load).
    m1  = nxt - CW'(1);
    k1  = m1 >> shamt;
    ph1 = m1[1:0] & pmask;
    // Offset 3: load strobe on phase 0, zeta read for the whole period.
    m3  = nxt - CW'(3);
    k3  = m3 >> shamt;
    ph3 = m3[1:0] & pmask;
    // Offset 4: processing window.
    m4  = nxt - CW'(4);
    k4  = m4 >> shamt;
    ph4 = m4[1:0] & pmask;
  end

  always_comb begin
    state_d       = state_q;
    cyc_d         = cyc_q;
    op_d          = op_q;
    bf_mode_d     = bf_mode_q;
    bf_type_d     = bf_type_q;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    mem_en_d      = 1'b0;
    mem_addr_d    = '0;
    zeta_en_d     = 1'b0;
    zeta_addr_d   = '0;
    bf_stage_d    = '0;
    bf_pre_load_d = 1'b0;
    bf_load_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          cyc_d     = '0;
          op_d      = op;
          bf_mode_d = op ? MODE_MULT : MODE_ADDSUB;
          bf_type_d = sub;
        end
      end

      S_RUN: begin
        cyc_d = nxt;
        if (nxt > last_busy) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;

          if (k1 < WORDS_C) begin
            if (ph1 == 2'd0) begin
              mem_en_d   = 1'b1;
              mem_addr_d = {1'b0, k1[AW-1:0]};
            end else if (ph1 == 2'd1) begin
              mem_en_d      = 1'b1;
              mem_addr_d    = {1'b1, k1[AW-1:0]};
              bf_pre_load_d = 1'b1;
            end
          end

          // The underflowed offsets (nxt < 3 or < 4) give huge indices and
          // are rejected by the explicit lower-bound checks.
          if (nxt >= CW'(3) && k3 < WORDS_C) begin
            if (ph3 == 2'd0)
              bf_load_d = 1'b1;
            if (op_q) begin
              zeta_en_d   = 1'b1;
              zeta_addr_d = k3[AW-1:0];
            end
          end

          if (nxt >= CW'(4) && k4 < WORDS_C) begin
            // MULT runs its four sub-steps rotated by two: 2, 3, 0, 1.
            bf_stage_d = op_q ? {1'b0, ph4 + 2'd2} : {2'b00, ph4};
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cyc_q         <= '0;
      op_q          <= 1'b0;
      bf_mode_q     <= '0;
      bf_type_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_addr_q    <= '0;
      zeta_en_q     <= 1'b0;
      zeta_addr_q   <= '0;
      bf_stage_q    <= '0;
      bf_pre_load_q <= 1'b0;
      bf_load_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      op_q          <= op_d;
      bf_mode_q     <= bf_mode_d;
      bf_type_q     <= bf_type_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      mem_en_q      <= mem_en_d;
      mem_addr_q    <= mem_addr_d;
      zeta_en_q     <= zeta_en_d;
      zeta_addr_q   <= zeta_addr_d;
      bf_stage_q    <= bf_stage_d;
      bf_pre_load_q <= bf_pre_load_d;
      bf_load_q     <= bf_load_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_en      = mem_en_q;
  assign mem_addr    = mem_addr_q;
  assign zeta_en     = zeta_en_q;
  assign zeta_addr   = zeta_addr_q;
  assign bf_mode     = bf_mode_q;
  assign bf_stage    = bf_stage_q;
  assign bf_type     = bf_type_q;
  assign bf_pre_load = bf_pre_load_q;
  assign bf_load     = bf_load_q;

  assign bf_in_data  = mem_rdata;
  // bf_mode resets to 0 (neither mode), so the coefficient is 0 out of reset.
  assign bf_in_coef  = (bf_mode_q == MODE_MULT) ? zeta_rdata : 24'd0;

endmodule

// File: tb/tb_poly_operand_feeder.sv
module tb_poly_operand_feeder;

  localparam int WORDS = 32;
  localparam int AW    = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start, op, sub;
  logic          busy, done, mem_en, zeta_en;
  logic [AW:0]   mem_addr;
  logic [AW-1:0] zeta_addr;
  logic [95:0]   mem_rdata = '0;
  logic [23:0]   zeta_rdata = '0;
  logic [1:0]    bf_mode;
  logic [2:0]    bf_stage;
  logic          bf_type, bf_pre_load, bf_load;
  logic [95:0]   bf_in_data;
  logic [23:0]   bf_in_coef;

  poly_operand_feeder #(.WORDS(WORDS), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .sub(sub),
    .busy(busy), .done(done),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .zeta_en(zeta_en), .zeta_addr(zeta_addr), .zeta_rdata(zeta_rdata),
    .bf_mode(bf_mode), .bf_stage(bf_stage), .bf_type(bf_type),
    .bf_pre_load(bf_pre_load), .bf_load(bf_load),
    .bf_in_data(bf_in_data), .bf_in_coef(bf_in_coef)
  );

  // RAM model: A word k = 8*k, B word k = 8*(k+1). Zeta word k = {k+100, k}.
  always @(posedge clk) begin
    if (mem_en)
      mem_rdata <= mem_addr[AW] ? 96'(8 * (int'(mem_addr[AW-1:0]) + 1))
                                : 96'(8 * int'(mem_addr[AW-1:0]));
    if (zeta_en)
      zeta_rdata <= {12'(int'(zeta_addr) + 100), 12'(int'(zeta_addr))};
  end

  wire [22:0] dut_ctl = {bf_mode, bf_type, busy, done, mem_en, mem_addr,
                         zeta_en, zeta_addr, bf_stage, bf_pre_load, bf_load};

  // ---------------- scoreboard ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [95:0] got,
                          input logic [95:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected control vector for cycle c of a run, built word by word.
  function automatic logic [22:0] exp_ctl(int c, bit m, bit s);
    int p;
    logic e_busy, e_done, e_men, e_zen, e_pl, e_ld;
    logic [AW:0] e_addr;
    logic [AW-1:0] e_za;
    logic [2:0] e_stage;
    p = m ? 4 : 2;
    e_busy = (c >= 1) && (c <= WORDS * p + 3);
    e_done = (c == WORDS * p + 4);
    e_men = 0; e_zen = 0; e_pl = 0; e_ld = 0;
    e_addr = '0; e_za = '0; e_stage = '0;
    for (int k = 0; k < WORDS; k++) begin
      int sk;
      sk = 1 + k * p;
      if (c == sk) begin e_men = 1; e_addr = {1'b0, AW'(k)}; end
      if (c == sk + 1) begin e_men = 1; e_addr = {1'b1, AW'(k)}; e_pl = 1; end
      if (c == sk + 2) e_ld = 1;
      if (m && c >= sk + 2 && c <= sk + 1 + p) begin e_zen = 1; e_za = AW'(k); end
      if (c >= sk + 3 && c <= sk + 2 + p)
        e_stage = m ? 3'((c - sk - 3 + 2) % 4) : 3'(c - sk - 3);
    end
    return {(m ? 2'd2 : 2'd3), s, e_busy, e_done, e_men, e_addr,
            e_zen, e_za, e_stage, e_pl, e_ld};
  endfunction

  // ---------------- driver ----------------
  // Called mid-cycle while the DUT is idle; presents start in this cycle.
  task automatic run_op(input bit m, input bit s, input bit inject,
                        input int abort_at);
    int p, last, reads, dones, k;
    logic [22:0] e;
    p = m ? 4 : 2;
    last = WORDS * p + 4;
    reads = 0;
    dones = 0;
    op = m; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_eq($sformatf("m%0d c0 ctl", m), 96'(dut_ctl),
             96'({(m ? 2'd2 : 2'd3), s, 20'b0}));
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      op = m;
      e = exp_ctl(c, m, s);
      check_eq($sformatf("m%0d c%0d ctl", m, c), 96'(dut_ctl), 96'(e));
      if (mem_en) reads++;
      if (done) dones++;
      if (e[1])
        check_eq($sformatf("m%0d c%0d A data", m, c), bf_in_data,
                 96'(8 * ((c - 2) / p)));
      if (e[0])
        check_eq($sformatf("m%0d c%0d B data", m, c), bf_in_data,
                 96'(8 * ((c - 3) / p + 1)));
      if (m && c >= 4 && c <= WORDS * p + 3) begin
        k = (c - 4) / p;
        check_eq($sformatf("m%0d c%0d coef", m, c), 96'(bf_in_coef),
                 96'({12'(k + 100), 12'(k)}));
      end
      if (!m)
        check_eq($sformatf("m%0d c%0d coef zero", m, c), 96'(bf_in_coef), 96'(0));
      if (c == abort_at) begin
        rst = 1'b1;
        #1;
        check_eq("async reset ctl", 96'(dut_ctl), 96'(0));
        check_eq("async reset coef", 96'(bf_in_coef), 96'(0));
        return;
      end
      if (inject && (c == 10 || c == 50)) begin
        start = 1'b1;
        op = !m;
      end
    end
    if (inject) begin
      check_eq("ignored start reads", 96'(reads), 96'(WORDS * 2));
      check_eq("ignored start dones", 96'(dones), 96'(1));
    end
  endtask

  // One idle cycle after a run: mode/type hold, everything else quiet.
  task automatic idle_hold(input bit m, input bit s);
    @(posedge clk); #1;
    check_eq("idle hold", 96'(dut_ctl), 96'({(m ? 2'd2 : 2'd3), s, 20'b0}));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("reset idle %0d", i), 96'(dut_ctl), 96'(0));
      check_eq($sformatf("reset coef %0d", i), 96'(bf_in_coef), 96'(0));
    end

    // ADDSUB add with stray starts, then MULT back-to-back.
    run_op(1'b0, 1'b0, 1'b1, 0);
    idle_hold(1'b0, 1'b0);
    run_op(1'b1, 1'b0, 1'b0, 0);
    idle_hold(1'b1, 1'b0);

    // MULT aborted by reset at cycle 40.
    run_op(1'b1, 1'b0, 1'b0, 40);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq($sformatf("post abort idle %0d", i), 96'(dut_ctl), 96'(0));
    end

    // Fresh MULT from word 0, then back-to-back ADDSUB subtract.
    run_op(1'b1, 1'b0, 1'b0, 0);
    idle_hold(1'b1, 1'b0);
    run_op(1'b0, 1'b1, 1'b0, 0);
    idle_hold(1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
